// File: rtl/tnn_feat_loader.sv
// Feature-stream loader for the sequential ternary classifier core: packs beats into
// a flat vector, times the inference window and returns the prediction as a result.
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready are both 1.
// A producer holds valid and its payload until that edge; ready never depends
// combinationally on the other side's valid/ready.
module tnn_feat_loader #(
    parameter int FEAT_CNT     = 16,
    parameter int FEAT_BITS    = 4,
    parameter int CLASS_CNT    = 10,
    parameter int INFER_CYCLES = 42,
    parameter int FRAME_BITS   = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [FEAT_BITS-1:0]          in_feat,
    input  logic                          in_last,
    output logic [FEAT_CNT*FEAT_BITS-1:0] data,
    output logic                          core_start,
    input  logic [$clog2(CLASS_CNT)-1:0]  core_pred,
    output logic                          res_valid,
    input  logic                          res_ready,
    output logic [$clog2(CLASS_CNT)-1:0]  res_class,
    output logic [FRAME_BITS-1:0]         res_frame,
    output logic                          res_err
);

    localparam int CW = $clog2(FEAT_CNT);
    localparam int RW = $clog2(INFER_CYCLES + 1);

    localparam logic [1:0] S_LOAD = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]            state;
    logic [CW-1:0]         feat_cnt;
    logic [RW-1:0]         run_cnt;
    logic [FRAME_BITS-1:0] frame;
    logic                  err;
    logic                  beat;
    logic                  last_slot;
    logic                  run_end;

    // Both ready/valid outputs are pure state decodes, so res_ready cannot reach in_ready.
    assign in_ready  = (state == S_LOAD);
    assign res_valid = (state == S_DONE);
    assign beat      = in_valid && in_ready;
    assign last_slot = (feat_cnt == CW'(FEAT_CNT - 1));
    assign run_end   = (run_cnt == RW'(INFER_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= S_LOAD;
            feat_cnt   <= '0;
            run_cnt    <= '0;
            frame      <= '0;
            err        <= 1'b0;
            data       <= '0;
            core_start <= 1'b0;
            res_class  <= '0;
            res_frame  <= '0;
            res_err    <= 1'b0;
        end else begin
            core_start <= 1'b0;
            case (state)
                S_LOAD: begin
                    if (beat) begin
                        data[feat_cnt*FEAT_BITS +: FEAT_BITS] <= in_feat;
                        // in_last only flags framing; the vector length is fixed.
                        if (in_last != last_slot) begin
                            err <= 1'b1;
                        end
                        if (last_slot) begin
                            state      <= S_RUN;
                            feat_cnt   <= '0;
                            run_cnt    <= '0;
                            core_start <= 1'b1;
                        end else begin
                            feat_cnt <= feat_cnt + 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (run_end) begin
                        res_class <= core_pred;
                        res_err   <= err;
                        res_frame <= frame;
                        run_cnt   <= '0;
                        state     <= S_DONE;
                    end else begin
                        run_cnt <= run_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    if (res_ready) begin
                        frame <= frame + 1'b1;
                        err   <= 1'b0;
                        state <= S_LOAD;
                    end
                end
                default: state <= S_LOAD;
            endcase
        end
    end

endmodule
